// File: rtl/adc_spi_cfg_master_if.sv
// Command/response handshake between a register-access client and adc_spi_cfg_master.
// The master modport drives commands; the slave modport is the SPI initiator.
interface adc_spi_cfg_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [1:0]  cmd_cs_mask;
    logic [12:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output cmd_valid, cmd_rw, cmd_cs_mask, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_cs_mask, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/adc_spi_cfg_master.sv
// 3-wire SPI initiator for the ADC A/B configuration ports: one 24-bit single-byte
// register frame per accepted command, with a registered response pulse.
module adc_spi_cfg_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                       SYS_CLK,
    input  logic                       RESET_N,
    adc_spi_cfg_master_if.slave        cmd_if,
    output logic                       spi_sclk,
    output logic                       spi_sdio_o,
    output logic                       spi_sdio_oe,
    input  logic                       spi_sdio_i,
    output logic                       spi_cs_a_n,
    output logic                       spi_cs_b_n
);

    typedef enum logic [2:0] {StIdle, StSetup, StBitHi, StBitLo, StHold, StGap} state_e;

    localparam logic [8:0] HalfMax = 9'(CLK_DIV - 1);
    localparam logic [8:0] GapMax  = 9'(2 * CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [22:0] frame_q, frame_d;
    logic        rw_q, rw_d;
    logic [1:0]  cs_q, cs_d;
    logic [7:0]  rd_q, rd_d;

    logic        sclk_q, sclk_d;
    logic        sdio_o_q, sdio_o_d;
    logic        sdio_oe_q, sdio_oe_d;
    logic        cs_a_n_q, cs_a_n_d;
    logic        cs_b_n_q, cs_b_n_d;
    logic        busy_q, busy_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    logic accept, illegal, half_done, hi_end, last_bit, frame_active;

    assign accept    = cmd_if.cmd_valid && cmd_ready_q;
    assign illegal   = (cmd_if.cmd_cs_mask == 2'b00) ||
                       (cmd_if.cmd_rw && (cmd_if.cmd_cs_mask == 2'b11));
    assign half_done = (cnt_q == HalfMax);
    assign last_bit  = (bit_q == 5'd23);
    assign hi_end    = (state_q == StBitHi) && half_done;

    always_ff @(posedge SYS_CLK) begin
        if (!RESET_N) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // The falling edge of bit 23 coincides with CS release, so BIT_HI 23 exits straight to GAP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && !illegal) state_d = StSetup;
            StSetup: if (half_done) state_d = StBitHi;
            StBitHi: if (half_done) state_d = last_bit ? StGap : StBitLo;
            StBitLo: if (half_done) state_d = StBitHi;
            StHold:  state_d = StGap;
            StGap:   if (cnt_q == GapMax) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d       = ((state_d != state_q) || (state_q == StIdle)) ? 9'd0 : cnt_q + 9'd1;
        bit_d       = bit_q;
        frame_d     = frame_q;
        rw_d        = rw_q;
        cs_d        = cs_q;
        rd_d        = rd_q;
        sdio_o_d    = sdio_o_q;
        sdio_oe_d   = sdio_oe_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        if (accept) begin
            rw_d    = cmd_if.cmd_rw;
            cs_d    = cmd_if.cmd_cs_mask;
            bit_d   = 5'd0;
            frame_d = {2'b00, cmd_if.cmd_addr, cmd_if.cmd_wdata};
            if (illegal) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = 8'h00;
            end else begin
                sdio_o_d  = cmd_if.cmd_rw;
                sdio_oe_d = 1'b1;
            end
        end

        if ((state_q == StBitLo) && half_done) bit_d = bit_q + 5'd1;

        if (hi_end) begin
            frame_d  = {frame_q[21:0], 1'b0};
            sdio_o_d = frame_q[22];
            // Turn the line around before the ADC starts driving the data byte.
            if (rw_q && (bit_q == 5'd15)) sdio_oe_d = 1'b0;
            if (last_bit) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = rw_q ? rd_q : 8'h00;
            end
        end

        if ((state_q == StBitHi) && (cnt_q == 9'd0) && bit_q[4]) rd_d = {rd_q[6:0], spi_sdio_i};

        frame_active = (state_d == StSetup) || (state_d == StBitHi) || (state_d == StBitLo);
        if (!frame_active) begin
            sdio_o_d  = 1'b0;
            sdio_oe_d = 1'b0;
        end

        sclk_d      = (state_d == StBitHi);
        cs_a_n_d    = !(frame_active && cs_d[0]);
        cs_b_n_d    = !(frame_active && cs_d[1]);
        busy_d      = (state_d != StIdle);
        cmd_ready_d = (state_d == StIdle) && !accept;
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RESET_N) begin
            cnt_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            rw_q        <= 1'b0;
            cs_q        <= 2'b00;
            rd_q        <= 8'h00;
            sclk_q      <= 1'b0;
            sdio_o_q    <= 1'b0;
            sdio_oe_q   <= 1'b0;
            cs_a_n_q    <= 1'b1;
            cs_b_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            rw_q        <= rw_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            sclk_q      <= sclk_d;
            sdio_o_q    <= sdio_o_d;
            sdio_oe_q   <= sdio_oe_d;
            cs_a_n_q    <= cs_a_n_d;
            cs_b_n_q    <= cs_b_n_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign spi_sclk         = sclk_q;
    assign spi_sdio_o       = sdio_o_q;
    assign spi_sdio_oe      = sdio_oe_q;
    assign spi_cs_a_n       = cs_a_n_q;
    assign spi_cs_b_n       = cs_b_n_q;
    assign cmd_if.cmd_ready = cmd_ready_q;
    assign cmd_if.busy      = busy_q;
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_err   = rsp_err_q;
    assign cmd_if.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_adc_spi_cfg_master.sv
// Self-checking bench for adc_spi_cfg_master: every cycle of each command is compared
// against a timeline computed arithmetically from the frame timing rules.
module tb_adc_spi_cfg_master;

    localparam int D       = 4;
    localparam int E       = 48 * D;     // last cycle (offset from T0) with CS low
    localparam int READY_N = 50 * D + 1; // offset at which cmd_ready returns

    logic SYS_CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic spi_sclk, spi_sdio_o, spi_sdio_oe, spi_sdio_i, spi_cs_a_n, spi_cs_b_n;

    adc_spi_cfg_master_if cmd_if ();

    adc_spi_cfg_master #(.CLK_DIV(D)) dut (
        .SYS_CLK     (SYS_CLK),
        .RESET_N     (RESET_N),
        .cmd_if      (cmd_if),
        .spi_sclk    (spi_sclk),
        .spi_sdio_o  (spi_sdio_o),
        .spi_sdio_oe (spi_sdio_oe),
        .spi_sdio_i  (spi_sdio_i),
        .spi_cs_a_n  (spi_cs_a_n),
        .spi_cs_b_n  (spi_cs_b_n)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_n  = 0;

    // Command queued behind the current one (held valid across the gap when p_valid).
    logic        p_valid = 1'b0;
    logic        p_rw    = 1'b0;
    logic [1:0]  p_mask  = 2'b00;
    logic [12:0] p_addr  = '0;
    logic [7:0]  p_wd    = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at T0+%0d: got 0x%0h, expected 0x%0h", tag, cur_n, got, exp);
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_cs_a_n",  spi_cs_a_n,          1);
        check_eq("rst_cs_b_n",  spi_cs_b_n,          1);
        check_eq("rst_sclk",    spi_sclk,            0);
        check_eq("rst_sdio_o",  spi_sdio_o,          0);
        check_eq("rst_sdio_oe", spi_sdio_oe,         0);
        check_eq("rst_busy",    cmd_if.busy,         0);
        check_eq("rst_ready",   cmd_if.cmd_ready,    1);
        check_eq("rst_rvalid",  cmd_if.rsp_valid,    0);
        check_eq("rst_rerr",    cmd_if.rsp_err,      0);
        check_eq("rst_rdata",   cmd_if.rsp_rdata,    8'h00);
    endtask

    task automatic drive_noise_cmd();
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_rw      = 1'($urandom);
        cmd_if.cmd_cs_mask = 2'($urandom);
        cmd_if.cmd_addr    = 13'($urandom);
        cmd_if.cmd_wdata   = 8'($urandom);
    endtask

    // Called at the falling edge of cycle T0; returns at the falling edge of the cycle
    // where the block is ready again (or just after a planted reset when rst_at > 0).
    task automatic run_cmd(input logic rw, input logic [1:0] mask, input logic [12:0] addr,
                           input logic [7:0] wd, input logic [7:0] adc_byte, input int rst_at);
        bit          legal;
        logic [23:0] frame;
        logic [7:0]  exp_rd;
        int          n_end, k;
        bit          cs_low, sclk_e, oe_e, rv_e;

        legal  = !((mask == 2'b00) || (rw && (mask == 2'b11)));
        frame  = {rw, 2'b00, addr, wd};
        exp_rd = rw ? adc_byte : 8'h00;
        n_end  = legal ? READY_N : 2;
        cur_n  = 0;
        check_eq("ready_at_t0", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_rw      = rw;
        cmd_if.cmd_cs_mask = mask;
        cmd_if.cmd_addr    = addr;
        cmd_if.cmd_wdata   = wd;

        for (int n = 1; n <= n_end; n++) begin
            @(negedge SYS_CLK);
            cur_n = n;
            if ((rst_at > 0) && (n == rst_at + 1)) begin
                check_reset_state();
                RESET_N = 1'b1;
                drive_noise_cmd();
                break;
            end
            cs_low = legal && (n >= 1) && (n <= E);
            sclk_e = cs_low && ((((n - 1) / D) % 2) == 1);
            oe_e   = cs_low && !(rw && (n >= 32 * D + 1));
            rv_e   = legal ? (n == E + 1) : (n == 1);
            check_eq("cs_a_n",  spi_cs_a_n,       !(cs_low && mask[0]));
            check_eq("cs_b_n",  spi_cs_b_n,       !(cs_low && mask[1]));
            check_eq("sclk",    spi_sclk,         sclk_e);
            check_eq("sdio_oe", spi_sdio_oe,      oe_e);
            check_eq("busy",    cmd_if.busy,      legal && (n <= 50 * D));
            check_eq("ready",   cmd_if.cmd_ready, n >= n_end);
            check_eq("rvalid",  cmd_if.rsp_valid, rv_e);
            if (oe_e) check_eq("sdio_o", spi_sdio_o, frame[23 - ((n - 1) / (2 * D))]);
            if (rv_e) check_eq("rerr", cmd_if.rsp_err, !legal);
            if (legal && (n >= E + 1)) check_eq("rdata", cmd_if.rsp_rdata, exp_rd);

            // ADC drives the data byte MSB first, changing just after each falling edge.
            k = (n - 1) / (2 * D);
            if (rw && legal && (k >= 16) && (k <= 23)) spi_sdio_i = adc_byte[23 - k];
            else                                       spi_sdio_i = 1'($urandom);

            if (n == rst_at) RESET_N = 1'b0;
            if (p_valid) begin
                cmd_if.cmd_valid   = 1'b1;
                cmd_if.cmd_rw      = p_rw;
                cmd_if.cmd_cs_mask = p_mask;
                cmd_if.cmd_addr    = p_addr;
                cmd_if.cmd_wdata   = p_wd;
            end else begin
                drive_noise_cmd();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        spi_sdio_i = 1'b0;
        drive_noise_cmd();
        RESET_N = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        check_reset_state();
        RESET_N = 1'b1;
        @(negedge SYS_CLK);
        check_reset_state();

        run_cmd(1'b0, 2'b01, 13'h0014, 8'h01, 8'h00, 0);
        run_cmd(1'b1, 2'b10, 13'h0001, 8'h00, 8'h56, 0);
        run_cmd(1'b0, 2'b11, 13'h00FF, 8'h01, 8'h00, 0);
        run_cmd(1'b0, 2'b00, 13'h0123, 8'h77, 8'h00, 0);
        run_cmd(1'b1, 2'b11, 13'h0042, 8'h00, 8'h99, 0);

        // Mid-frame reset, then confirm no stray response and a clean follow-up frame.
        run_cmd(1'b0, 2'b01, 13'h0ABC, 8'hA5, 8'h00, 60);
        repeat (3) begin
            @(negedge SYS_CLK);
            check_eq("post_rst_rvalid", cmd_if.rsp_valid, 0);
            check_eq("post_rst_cs_a_n", spi_cs_a_n, 1);
        end
        run_cmd(1'b1, 2'b01, 13'h1F0E, 8'h00, 8'hC3, 0);

        // Second command held valid across the gap of the first.
        p_valid = 1'b1;
        p_rw    = 1'b1;
        p_mask  = 2'b10;
        p_addr  = 13'h0155;
        p_wd    = 8'h00;
        run_cmd(1'b0, 2'b11, 13'h0008, 8'h5A, 8'h00, 0);
        p_valid = 1'b0;
        run_cmd(p_rw, p_mask, p_addr, p_wd, 8'h3E, 0);

        for (int i = 0; i < 8; i++) begin
            run_cmd(1'($urandom), 2'($urandom), 13'($urandom), 8'($urandom), 8'($urandom), 0);
            repeat ($urandom_range(0, 3)) @(negedge SYS_CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
